iq_credit_ctrl: RTL

Per-port credit controller between rename/dispatch and the integer issue queues. The upstream port-assignment logic tags each uop of a dispatch group with a target ALU port. This block tracks free issue-queue slots per port and stalls the group when any port would overflow. It also supplies the round-robin starting-port hint back to the port-assignment logic and runs the post-flush recovery sequence.

---
 rtl/iq_credit_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/iq_credit_ctrl.sv
// iq_credit_ctrl: per-port issue-queue credit tracking for the integer
// dispatch path. It stalls a dispatch group that would overflow any queue,
// feeds the round-robin start-port hint back to port assignment, and holds
// dispatch off for a fixed window after a pipeline flush.
//
// Handshake: IN_valid offers a dispatch group; !OUT_stall is the ready.
// A group transfers (is accepted) exactly when IN_valid && !OUT_stall,
// and then every valid slot of that group is dispatched together.
module iq_credit_ctrl #(
   parameter int NUM_PORTS    = 4,
   parameter int DEC_WIDTH    = 4,
   parameter int IQ_DEPTH     = 8,
   parameter int FLUSH_CYCLES = 2,
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
   localparam int FW = $clog2(IQ_DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    IN_valid,
   input  logic [DEC_WIDTH-1:0]    IN_uopValid,
   input  logic [DEC_WIDTH*PW-1:0] IN_order,
   input  logic [NUM_PORTS-1:0]    IN_issue,
   input  logic                    IN_flush,
   output logic                    OUT_stall,
   output logic [NUM_PORTS*FW-1:0] OUT_free,
   output logic [PW-1:0]           OUT_prio,
   output logic                    OUT_error,
   output logic                    dbg_state
);

   // demand counter width, credit arithmetic width (one bit of headroom), flush counter width
   localparam int DW = $clog2(DEC_WIDTH + 1);
   localparam int AW = ((FW > DW) ? FW : DW) + 1;
   localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   localparam logic [PW:0]   NP_W    = (PW + 1)'(NUM_PORTS);
   localparam logic [AW-1:0] DEPTH_A = AW'(IQ_DEPTH);
   localparam logic [FW-1:0] DEPTH_F = FW'(IQ_DEPTH);
   localparam logic [CW-1:0] CNT_LD  = CW'(FLUSH_CYCLES - 1);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [FW-1:0]   free_q [NUM_PORTS];
   logic [FW-1:0]   free_d [NUM_PORTS];
   logic [PW-1:0]   prio_q, prio_d;
   logic            err_q, err_d;

   logic [DW-1:0]   demand [NUM_PORTS];
   logic [AW-1:0]   sum    [NUM_PORTS];
   logic            over;
   logic            accept;
   logic            any_valid;
   logic [PW-1:0]   last_ord;
   logic [PW:0]     prio_inc;
   logic [PW-1:0]   prio_wrap;

   // count how many valid slots of the offered group target each port
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         demand[p] = '0;
         for (int i = 0; i < DEC_WIDTH; i++) begin
            if (IN_uopValid[i] && (IN_order[i*PW +: PW] == PW'(p))) begin
               demand[p] = demand[p] + DW'(1);
            end
         end
      end
   end

   // stall decision uses registered credits only; same-cycle issues are not credited
   always_comb begin
      over = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (AW'(demand[p]) > AW'(free_q[p])) begin
            over = 1'b1;
         end
      end
      OUT_stall = (state_q == ST_FLUSH) || IN_flush || (IN_valid && over);
      accept    = IN_valid && !OUT_stall && !IN_flush;
   end

   // next round-robin hint: one past the port of the last valid slot, wrapped
   always_comb begin
      last_ord  = '0;
      any_valid = 1'b0;
      for (int i = 0; i < DEC_WIDTH; i++) begin
         if (IN_uopValid[i]) begin
            last_ord  = IN_order[i*PW +: PW];
            any_valid = 1'b1;
         end
      end
      prio_inc  = {1'b0, last_ord} + (PW + 1)'(1);
      prio_wrap = PW'((prio_inc >= NP_W) ? (prio_inc - NP_W) : prio_inc);
   end

   // per-port credit result before saturation: free - accepted demand + issue
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         sum[p] = AW'(free_q[p]) - (accept ? AW'(demand[p]) : '0) + AW'(IN_issue[p]);
      end
   end

   // RUN/FLUSH next-state, credit, hint and error update; flush wins over everything
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      free_d  = free_q;
      prio_d  = prio_q;
      err_d   = err_q;
      if (IN_flush) begin
         state_d = ST_FLUSH;
         cnt_d   = CNT_LD;
         prio_d  = '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            free_d[p] = DEPTH_F;
         end
      end else if (state_q == ST_FLUSH) begin
         // credits stay full and issues are ignored until the window closes
         if (cnt_q == '0) begin
            state_d = ST_RUN;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (sum[p] > DEPTH_A) begin
               free_d[p] = DEPTH_F;
               err_d     = 1'b1;
            end else begin
               free_d[p] = sum[p][FW-1:0];
            end
         end
         if (accept && any_valid) begin
            prio_d = prio_wrap;
         end
      end
   end

   // state registers with asynchronous reset to the full-credit RUN state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         prio_q  <= '0;
         err_q   <= 1'b0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            free_q[p] <= DEPTH_F;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prio_q  <= prio_d;
         err_q   <= err_d;
         for (int p = 0; p < NUM_PORTS; p++) begin
            free_q[p] <= free_d[p];
         end
      end
   end

   // pack registered state onto the outputs
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         OUT_free[p*FW +: FW] = free_q[p];
      end
      OUT_prio  = prio_q;
      OUT_error = err_q;
      dbg_state = (state_q == ST_FLUSH);
   end

endmodule
